group_8_mac_sequencer: RTL and testbench

GROUP_8_MAC_SEQUENCER -- requirements
Module: group_8_mac_sequencer

---
 rtl/group_8_mac_sequencer_pkg.sv | 19 +
 rtl/group_8_mac_lat_counter.sv | 36 +++
 rtl/group_8_mac_sequencer.sv | 174 +++++++++++++++++
 tb/tb_group_8_mac_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/group_8_mac_sequencer_pkg.sv
// Shared types and widths for the group-8 MAC sequencer.
// Lane geometry, accumulator/error widths and FSM states.
package group_8_mac_sequencer_pkg;

    localparam int LANE_W  = 8;
    localparam int LANES   = 8;
    localparam int VEC_W   = LANE_W * LANES;
    localparam int ACC_W   = 24;
    localparam int EPROD_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_OUT
    } state_e;

endpackage

// File: rtl/group_8_mac_lat_counter.sv
// MAC latency down-counter shared by WAIT and DRAIN.
// done_o fires in the cycle the MAC outputs are valid.
module group_8_mac_lat_counter #(
    parameter int MAC_LATENCY = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int CW = $clog2(MAC_LATENCY + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // load on issue, count down while waiting
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CW'(MAC_LATENCY);
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // counter register
    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done_o = en_i && (cnt_q == CW'(1));

endmodule

// File: rtl/group_8_mac_sequencer.sv
// Sequences 8-lane tiles through an external MAC with
// error-compensation feedback and a final drain issue.
module group_8_mac_sequencer
    import group_8_mac_sequencer_pkg::*;
#(
    parameter int MAC_LATENCY = 2,
    parameter int TILE_W      = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [TILE_W-1:0]  num_tiles,
    input  logic [ACC_W-1:0]   bias_in,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [VEC_W-1:0]   in_weights,
    input  logic [VEC_W-1:0]   in_activations,
    output logic [VEC_W-1:0]   mac_weights,
    output logic [VEC_W-1:0]   mac_activations,
    output logic [ACC_W-1:0]   mac_partial_sum_in,
    output logic [EPROD_W-1:0] mac_error_product_in,
    output logic               mac_error_in,
    input  logic [ACC_W-1:0]   mac_partial_sum_out,
    input  logic [EPROD_W-1:0] mac_error_product_out,
    input  logic               mac_error_out,
    output logic [ACC_W-1:0]   result,
    output logic               result_valid,
    input  logic               result_ready,
    output logic               busy
);

    state_e              state_q, state_d;
    logic [TILE_W-1:0]   tile_q, tile_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                epend_q, epend_d;
    logic [EPROD_W-1:0]  eprod_q, eprod_d;
    logic [VEC_W-1:0]    w_q, w_d;
    logic [VEC_W-1:0]    a_q, a_d;
    logic [ACC_W-1:0]    psin_q, psin_d;
    logic [EPROD_W-1:0]  epin_q, epin_d;
    logic                ein_q, ein_d;
    logic [ACC_W-1:0]    res_q, res_d;
    logic                lat_load;
    logic                lat_en;
    logic                lat_done;

    group_8_mac_lat_counter #(
        .MAC_LATENCY(MAC_LATENCY)
    ) u_lat (
        .clk   (clk),
        .rst_n (rst_n),
        .load_i(lat_load),
        .en_i  (lat_en),
        .done_o(lat_done)
    );

    // next-state, datapath and MAC issue decisions
    always_comb begin
        state_d  = state_q;
        tile_d   = tile_q;
        acc_d    = acc_q;
        epend_d  = epend_q;
        eprod_d  = eprod_q;
        w_d      = w_q;
        a_d      = a_q;
        psin_d   = psin_q;
        epin_d   = epin_q;
        ein_d    = ein_q;
        res_d    = res_q;
        lat_load = 1'b0;
        lat_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    tile_d  = num_tiles;
                    acc_d   = bias_in;
                    epend_d = 1'b0;
                    eprod_d = '0;
                    state_d = (num_tiles == '0) ? S_OUT : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (in_valid) begin
                    w_d      = in_weights;
                    a_d      = in_activations;
                    psin_d   = acc_q;
                    ein_d    = epend_q;
                    epin_d   = eprod_q;
                    tile_d   = tile_q - TILE_W'(1);
                    lat_load = 1'b1;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                lat_en = 1'b1;
                ein_d  = 1'b0;
                if (lat_done) begin
                    acc_d   = mac_partial_sum_out;
                    epend_d = mac_error_out;
                    eprod_d = mac_error_out ? mac_error_product_out : '0;
                    if (tile_q != '0) begin
                        state_d = S_ISSUE;
                    end else if (mac_error_out) begin
                        // last tile left an error: one zero-operand issue
                        w_d      = '0;
                        a_d      = '0;
                        psin_d   = mac_partial_sum_out;
                        ein_d    = 1'b1;
                        epin_d   = mac_error_product_out;
                        lat_load = 1'b1;
                        state_d  = S_DRAIN;
                    end else begin
                        state_d = S_OUT;
                    end
                end
            end
            S_DRAIN: begin
                lat_en = 1'b1;
                ein_d  = 1'b0;
                if (lat_done) begin
                    acc_d   = mac_partial_sum_out;
                    epend_d = 1'b0;
                    eprod_d = '0;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (result_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_OUT && state_q != S_OUT) res_d = acc_d;
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tile_q  <= '0;
            acc_q   <= '0;
            epend_q <= 1'b0;
            eprod_q <= '0;
            w_q     <= '0;
            a_q     <= '0;
            psin_q  <= '0;
            epin_q  <= '0;
            ein_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            tile_q  <= tile_d;
            acc_q   <= acc_d;
            epend_q <= epend_d;
            eprod_q <= eprod_d;
            w_q     <= w_d;
            a_q     <= a_d;
            psin_q  <= psin_d;
            epin_q  <= epin_d;
            ein_q   <= ein_d;
            res_q   <= res_d;
        end
    end

    assign in_ready             = (state_q == S_ISSUE);
    assign result_valid         = (state_q == S_OUT);
    assign busy                 = (state_q != S_IDLE);
    assign result               = res_q;
    assign mac_weights          = w_q;
    assign mac_activations      = a_q;
    assign mac_partial_sum_in   = psin_q;
    assign mac_error_product_in = epin_q;
    assign mac_error_in         = ein_q;

endmodule

// File: tb/tb_group_8_mac_sequencer.sv
// Randomized bench for group_8_mac_sequencer with a
// behavioural MAC and a job-level result model.
module tb_group_8_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  num_tiles = '0;
    logic [23:0] bias_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_weights = '0;
    logic [63:0] in_activations = '0;
    logic [63:0] mac_weights;
    logic [63:0] mac_activations;
    logic [23:0] mac_partial_sum_in;
    logic [15:0] mac_error_product_in;
    logic        mac_error_in;
    logic [23:0] mac_partial_sum_out = '0;
    logic [15:0] mac_error_product_out = '0;
    logic        mac_error_out = 1'b0;
    logic [23:0] result;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic        busy;

    int n_checks = 0;
    int n_fail = 0;

    group_8_mac_sequencer #(
        .MAC_LATENCY(2),
        .TILE_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .num_tiles(num_tiles),
        .bias_in(bias_in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_weights(in_weights),
        .in_activations(in_activations),
        .mac_weights(mac_weights),
        .mac_activations(mac_activations),
        .mac_partial_sum_in(mac_partial_sum_in),
        .mac_error_product_in(mac_error_product_in),
        .mac_error_in(mac_error_in),
        .mac_partial_sum_out(mac_partial_sum_out),
        .mac_error_product_out(mac_error_product_out),
        .mac_error_out(mac_error_out),
        .result(result),
        .result_valid(result_valid),
        .result_ready(result_ready),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dot8(input logic [63:0] w,
                                         input logic [63:0] a);
        logic [31:0] s;
        s = 0;
        for (int k = 0; k < 8; k++)
            s += 32'(w[8*k +: 8]) * 32'(a[8*k +: 8]);
        return s;
    endfunction

    // behavioural MAC: two-cycle latency, error flagged per issued tile
    logic        plan_en = 1'b0;
    logic [15:0] plan_v = '0;
    logic        cur_en = 1'b0;
    logic [15:0] cur_v = '0;
    int          xfers = 0;

    always @(posedge clk) begin
        if (in_valid && in_ready) begin
            cur_en <= plan_en;
            cur_v  <= plan_v;
            xfers  <= xfers + 1;
        end
        mac_partial_sum_out <= 24'(32'(mac_partial_sum_in)
            + dot8(mac_weights, mac_activations)
            + (mac_error_in ? 32'(mac_error_product_in) : 32'd0));
        mac_error_out         <= cur_en;
        mac_error_product_out <= cur_v;
    end

    // feedback monitor: every flagged error must come back exactly once
    logic [15:0] eq[$];
    int          pulses = 0;
    int          drains = 0;
    int          busy_low = 0;
    bit          job_active = 0;

    always @(negedge clk) begin
        if (job_active && !busy) busy_low++;
        if (rst_n && mac_error_in) begin
            pulses++;
            if (mac_weights == '0 && mac_activations == '0) drains++;
            if (eq.size() == 0) check("err_fb_extra", 1, 0);
            else check("err_fb_prod", mac_error_product_in, eq.pop_front());
        end
    end

    logic [63:0] tw[16];
    logic [63:0] ta[16];
    bit          te[16];
    logic [15:0] tv[16];

    task automatic run_job(input logic [23:0] bias, input int n,
                           input int gap, input int rd);
        logic [31:0] exp;
        int          n_err;
        int          x0;
        bit          ok;
        exp = 32'(bias);
        n_err = 0;
        eq.delete();
        for (int k = 0; k < n; k++) begin
            exp += dot8(tw[k], ta[k]) + (te[k] ? 32'(tv[k]) : 32'd0);
            if (te[k]) begin
                n_err++;
                eq.push_back(tv[k]);
            end
        end
        pulses = 0;
        drains = 0;
        busy_low = 0;
        x0 = xfers;
        start = 1'b1;
        num_tiles = 8'(n);
        bias_in = bias;
        @(negedge clk);
        start = 1'b0;
        job_active = 1;
        for (int k = 0; k < n; k++) begin
            ok = 0;
            for (int t = 0; t < 50; t++) begin
                if (in_ready) begin
                    ok = 1;
                    break;
                end
                @(negedge clk);
            end
            if (!ok) begin
                check("in_ready_timeout", 0, 1);
                job_active = 0;
                return;
            end
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                check("issue_hold", in_ready, 1);
            end
            in_valid = 1'b1;
            in_weights = tw[k];
            in_activations = ta[k];
            plan_en = te[k];
            plan_v = tv[k];
            @(negedge clk);
            in_valid = 1'b0;
        end
        ok = 0;
        for (int t = 0; t < 100; t++) begin
            if (result_valid) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("result_timeout", 0, 1);
            job_active = 0;
            return;
        end
        check("result", result, 64'(exp[23:0]));
        for (int r = 0; r < rd; r++) begin
            @(negedge clk);
            check("result_hold_v", result_valid, 1);
            check("result_hold", result, 64'(exp[23:0]));
        end
        job_active = 0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("busy_after", busy, 0);
        check("valid_after", result_valid, 0);
        check("result_kept", result, 64'(exp[23:0]));
        check("busy_in_job", busy_low, 0);
        check("xfers", xfers - x0, n);
        check("fb_pulses", pulses, n_err);
        check("drains", drains, (n > 0 && te[n-1]) ? 1 : 0);
        check("fb_left", eq.size(), 0);
    endtask

    task automatic load_req34(input int k);
        for (int j = 0; j < 8; j++) begin
            tw[k][8*j +: 8] = 8'(2*j + 1);
            ta[k][8*j +: 8] = 8'(2*j + 2);
        end
        te[k] = 0;
        tv[k] = '0;
    endtask

    task automatic load_req35(input int k);
        for (int j = 0; j < 8; j++) begin
            tw[k][8*j +: 8] = 8'(16 - 2*j);
            ta[k][8*j +: 8] = 8'(15 - 2*j);
        end
        te[k] = 0;
        tv[k] = '0;
    endtask

    initial begin
        int quiet;
        int n;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_valid", result_valid, 0);
        check("rst_result", result, 0);
        check("rst_w", mac_weights, 0);
        check("rst_psin", mac_partial_sum_in, 0);
        check("rst_ein", mac_error_in, 0);
        rst_n = 1'b1;
        @(negedge clk);

        load_req34(0);
        run_job(24'h008000, 1, 0, 0);
        check("req34_abs", result, 24'h0082E8);

        load_req34(0);
        load_req35(1);
        run_job(24'h004000, 2, 0, 0);
        check("req35_abs", result, 24'h0045D0);

        load_req34(0);
        load_req35(1);
        te[0] = 1;
        tv[0] = 16'h0012;
        run_job(24'h004000, 2, 0, 0);
        check("req36_abs", result, 24'h0045E2);

        load_req34(0);
        te[0] = 1;
        tv[0] = 16'h0012;
        run_job(24'h008000, 1, 0, 0);
        check("req37_abs", result, 24'h0082FA);

        run_job(24'hABCDEF, 0, 0, 0);
        check("zero_tiles_abs", result, 24'hABCDEF);

        load_req34(0);
        run_job(24'h000100, 1, 5, 3);

        for (int it = 0; it < 40; it++) begin
            n = $urandom_range(0, 4);
            for (int k = 0; k < 4; k++) begin
                tw[k] = {$urandom, $urandom};
                ta[k] = {$urandom, $urandom};
                te[k] = ($urandom_range(0, 2) == 0);
                tv[k] = 16'($urandom);
            end
            run_job(24'($urandom), n, $urandom_range(0, 2),
                    $urandom_range(0, 2));
        end

        load_req34(0);
        load_req35(1);
        plan_en = 0;
        start = 1'b1;
        num_tiles = 8'd2;
        bias_in = 24'h004000;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 50 && !in_ready; t++) @(negedge clk);
            check("mid_rst_ready", in_ready, 1);
            in_valid = 1'b1;
            in_weights = tw[k];
            in_activations = ta[k];
            @(negedge clk);
            in_valid = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready0", in_ready, 0);
        check("mid_rst_valid", result_valid, 0);
        check("mid_rst_result", result, 0);
        check("mid_rst_w", mac_weights, 0);
        check("mid_rst_a", mac_activations, 0);
        check("mid_rst_psin", mac_partial_sum_in, 0);
        check("mid_rst_eprod", mac_error_product_in, 0);
        check("mid_rst_ein", mac_error_in, 0);
        rst_n = 1'b1;
        quiet = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (result_valid || busy) quiet++;
        end
        check("mid_rst_quiet", quiet, 0);

        load_req34(0);
        run_job(24'h008000, 1, 1, 1);
        check("recover_abs", result, 24'h0082E8);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
